// File: rtl/duplex_ctrl.sv
// Half-duplex push-to-talk scheduler for the shared DDS / modulator / demodulator path.
// Sequences RX_SETTLE -> RX -> GUARD_TX -> TX_SETTLE -> TX -> GUARD_RX, and owns the
// centre-frequency word and the AM/FM select. New settings are accepted into shadow
// registers at any time and reach the carrier path only on settle entry, so the DDS
// never retunes while audio is live.
module duplex_ctrl #(
    parameter int unsigned            PHASE_WIDTH   = 32,
    parameter int unsigned            GUARD_CYCLES  = 1000,
    parameter int unsigned            SETTLE_CYCLES = 4000,
    parameter logic [PHASE_WIDTH-1:0] RST_RX_WORD   = PHASE_WIDTH'(459561501),
    parameter logic [PHASE_WIDTH-1:0] RST_TX_WORD   = PHASE_WIDTH'(459561501),
    parameter logic                   RST_AM_SEL    = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   sys_rst_n,
    input  logic                   ptt_req,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_tx_word,
    input  logic [PHASE_WIDTH-1:0] cfg_rx_word,
    input  logic                   cfg_am_sel,
    output logic [PHASE_WIDTH-1:0] center_fre,
    output logic                   am_sel,
    output logic                   mod_en,
    output logic                   demod_en,
    output logic                   tx_mute,
    output logic                   rx_mute,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        StRxSettle = 3'd0,
        StRx       = 3'd1,
        StGuardTx  = 3'd2,
        StTxSettle = 3'd3,
        StTx       = 3'd4,
        StGuardRx  = 3'd5
    } state_e;

    localparam int unsigned CntMax = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES
                                                                     : SETTLE_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] GuardLast  = CntW'(GUARD_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic [PHASE_WIDTH-1:0] shadow_tx_q, shadow_tx_d;
    logic [PHASE_WIDTH-1:0] shadow_rx_q, shadow_rx_d;
    logic                   shadow_am_q, shadow_am_d;
    logic [PHASE_WIDTH-1:0] center_q, center_d;
    logic                   am_q, am_d;
    logic                   mod_en_q, mod_en_d;
    logic                   demod_en_q, demod_en_d;
    logic                   tx_mute_q, tx_mute_d;
    logic                   rx_mute_q, rx_mute_d;
    logic                   xfer;
    logic                   enter_rx_settle;
    logic                   enter_tx_settle;

    // Next state, counter, config handshake/apply and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        pending_d   = pending_q;
        shadow_tx_d = shadow_tx_q;
        shadow_rx_d = shadow_rx_q;
        shadow_am_d = shadow_am_q;
        center_d    = center_q;
        am_d        = am_q;
        mod_en_d    = 1'b0;
        demod_en_d  = 1'b0;
        tx_mute_d   = 1'b1;
        rx_mute_d   = 1'b1;

        xfer = cfg_valid & cfg_ready_q;

        case (state_q)
            StRxSettle: if (cnt_q == SettleLast) state_d = StRx;
            StGuardTx:  if (cnt_q == GuardLast)  state_d = StTxSettle;
            StTxSettle: if (cnt_q == SettleLast) state_d = StTx;
            StGuardRx:  if (cnt_q == GuardLast)  state_d = StRxSettle;
            StRx: begin
                // Transmit request outranks a receive-side retune.
                if (ptt_req)        state_d = StGuardTx;
                else if (pending_q) state_d = StGuardRx;
            end
            StTx: begin
                if (!ptt_req)       state_d = StGuardRx;
                else if (pending_q) state_d = StGuardTx;
            end
            default: state_d = StRxSettle;
        endcase

        // Steady states keep the counter parked at zero; any change restarts it.
        if (state_d != state_q || state_q == StRx || state_q == StTx) begin
            cnt_d = '0;
        end

        enter_rx_settle = (state_d == StRxSettle) && (state_q != StRxSettle);
        enter_tx_settle = (state_d == StTxSettle) && (state_q != StTxSettle);

        if (enter_rx_settle) begin
            center_d  = shadow_rx_q;
            am_d      = shadow_am_q;
            pending_d = 1'b0;
        end else if (enter_tx_settle) begin
            center_d  = shadow_tx_q;
            am_d      = shadow_am_q;
            pending_d = 1'b0;
        end

        // A transfer on an apply edge lands after the copy and stays pending.
        if (xfer) begin
            shadow_tx_d = cfg_tx_word;
            shadow_rx_d = cfg_rx_word;
            shadow_am_d = cfg_am_sel;
            pending_d   = 1'b1;
        end

        cfg_ready_d = ~pending_d;

        case (state_d)
            StRxSettle: demod_en_d = 1'b1;
            StRx: begin
                demod_en_d = 1'b1;
                rx_mute_d  = 1'b0;
            end
            StTxSettle: mod_en_d = 1'b1;
            StTx: begin
                mod_en_d  = 1'b1;
                tx_mute_d = 1'b0;
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            state_q     <= StRxSettle;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            shadow_tx_q <= RST_TX_WORD;
            shadow_rx_q <= RST_RX_WORD;
            shadow_am_q <= RST_AM_SEL;
            center_q    <= RST_RX_WORD;
            am_q        <= RST_AM_SEL;
            mod_en_q    <= 1'b0;
            demod_en_q  <= 1'b0;
            tx_mute_q   <= 1'b1;
            rx_mute_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
            shadow_tx_q <= shadow_tx_d;
            shadow_rx_q <= shadow_rx_d;
            shadow_am_q <= shadow_am_d;
            center_q    <= center_d;
            am_q        <= am_d;
            mod_en_q    <= mod_en_d;
            demod_en_q  <= demod_en_d;
            tx_mute_q   <= tx_mute_d;
            rx_mute_q   <= rx_mute_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign center_fre = center_q;
    assign am_sel     = am_q;
    assign mod_en     = mod_en_q;
    assign demod_en   = demod_en_q;
    assign tx_mute    = tx_mute_q;
    assign rx_mute    = rx_mute_q;
    assign state      = state_q;

endmodule

// File: doc/duplex_ctrl.md
Name: duplex_ctrl

Overview:
- Half-duplex push-to-talk scheduler for the shared carrier path: DDS, AM/FM modulator and AM/FM demodulator.
- Owns the single centre-frequency word and the modulation-mode select.
- Switches the path between receive and transmit, with a guard interval (both directions off) and a settle interval (carrier on, audio muted).
- Accepts new tune/mode settings via a valid/ready handshake and applies them only at settle entry, so the DDS never retunes while audio is live.

Parameters:
PHASE_WIDTH, 32, width of frequency words (matches DDS phase accumulator)
GUARD_CYCLES, 1000, cycles spent in each guard state (>=1)
SETTLE_CYCLES, 4000, cycles spent in each settle state (>=1)
RST_RX_WORD, 459561501, receive frequency word after reset (10.7 MHz at 100 MHz clock)
RST_TX_WORD, 459561501, transmit frequency word after reset
RST_AM_SEL, 1, modulation mode after reset (1=AM, 0=FM)

Ports:
clk_in  in  1  system clock
sys_rst_n  in  1  reset; synchronous, active-low
ptt_req  in  1  push-to-talk level; 1 = request transmit
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration slot free
cfg_tx_word  in  PHASE_WIDTH  new transmit frequency word
cfg_rx_word  in  PHASE_WIDTH  new receive frequency word
cfg_am_sel  in  1  new mode (1=AM, 0=FM)
center_fre  out  PHASE_WIDTH  frequency word to modulator center_fre / demodulator Fre_word
am_sel  out  1  active mode to modulator/demodulator output mux
mod_en  out  1  modulator/transmit enable
demod_en  out  1  demodulator enable
tx_mute  out  1  mutes transmit audio input
rx_mute  out  1  mutes receive audio output
state  out  3  current state encoding (debug)

Behaviour:
- All outputs registered. Clock is clk_in only.
- sys_rst_n sampled low at a clock edge: state=RX_SETTLE, counter=0, center_fre=RST_RX_WORD, am_sel=RST_AM_SEL, mod_en=0, demod_en=0, tx_mute=1, rx_mute=1, cfg_ready=0, pending=0.
- Shadow regs load RST_TX_WORD / RST_RX_WORD / RST_AM_SEL during reset.
- Reset mid-operation aborts any state immediately; a pending config is discarded.
- State encodings:
  - RX_SETTLE=0: demod_en=1, mod_en=0, rx_mute=1, tx_mute=1.
  - RX=1: demod_en=1, rx_mute=0.
  - GUARD_TX=2: all enables 0, both mutes 1.
  - TX_SETTLE=3: mod_en=1, tx_mute=1.
  - TX=4: mod_en=1, tx_mute=0.
  - GUARD_RX=5: all enables 0, both mutes 1.
- Timed states: counter runs 0..N-1; the state is held exactly N cycles (N=GUARD_CYCLES or SETTLE_CYCLES). Counter clears on every state change.
- Transitions:
  - RX_SETTLE -> RX at count end.
  - GUARD_TX -> TX_SETTLE at count end.
  - TX_SETTLE -> TX at count end.
  - GUARD_RX -> RX_SETTLE at count end.
- RX:
  - ptt_req=1 -> GUARD_TX.
  - Else pending=1 -> GUARD_RX (retune in receive).
  - ptt_req has priority over pending.
- TX:
  - ptt_req=0 -> GUARD_RX.
  - Else pending=1 -> GUARD_TX (retune in transmit).
- ptt_req is ignored in guard/settle states; it is re-evaluated on the first steady-state cycle. Minimum TX dwell is therefore 1 cycle after TX_SETTLE.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at a clock edge.
  - Shadow regs capture all three cfg_* fields; pending=1; cfg_ready=0 from the next cycle.
  - First cycle after reset release: cfg_ready=1.
- Apply:
  - On the edge entering RX_SETTLE: center_fre<=shadow_rx, am_sel<=shadow_am.
  - On the edge entering TX_SETTLE: center_fre<=shadow_tx, am_sel<=shadow_am.
  - Shadows are copied even when not pending; pending clears at the same edge; cfg_ready=1 the next cycle.
  - A transfer on that same edge is impossible (cfg_ready=0 while pending).
  - If pending=0 at the apply edge, a transfer on that edge lands in the shadow after the copy; the new values apply at the next settle entry.
- center_fre and am_sel never change outside settle-entry edges.

Test Plan:
(GUARD_CYCLES=4, SETTLE_CYCLES=8 for sim)
- Reset release, ptt_req=0 -> RX_SETTLE for 8 cycles, then RX with rx_mute=0, demod_en=1, center_fre=459561501; cfg_ready=1 one cycle after release.
- ptt_req 0->1 in RX -> GUARD_TX 4 cycles (mod_en=demod_en=0, both mutes 1), TX_SETTLE 8 cycles, TX with mod_en=1, tx_mute=0; ptt_req->0 -> GUARD_RX 4 cycles, RX_SETTLE 8 cycles, RX.
- In RX, write cfg_rx_word=32'd42950, cfg_am_sel=0 -> cfg_ready drops next cycle; center_fre stays until GUARD_RX(4) ends; becomes 42950 with am_sel=0 on RX_SETTLE entry; cfg_ready returns 1 next cycle.
- In RX, ptt_req=1 and cfg_valid accepted on the same edge (new tx word 32'd1000) -> GUARD_TX taken (no GUARD_RX); TX_SETTLE entry loads center_fre=1000, pending clears.
- ptt_req pulsed 1 for 2 cycles during GUARD_RX -> ignored, RX reached, no new TX cycle; ptt_req dropped during TX_SETTLE -> TX held exactly 1 cycle, then GUARD_RX.
- sys_rst_n low for 1 cycle mid TX_SETTLE with pending config -> next cycle all outputs at reset values, pending cleared, center_fre=RST_RX_WORD, sequence restarts at RX_SETTLE.
